// File: rtl/mem_view_pkg.sv
// Shared types and constants for the memory view scanner.
package mem_view_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Number of hex digits on the display
  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns {g,f,e,d,c,b,a} for nibbles 0..F
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/mem_view_scanner_if.sv
// Memory read bus between the scanner and the instruction/data memories.
//
// Handshake: mem_rd_en is a one-cycle strobe with no back-pressure (there is
// no ready). mem_addr is stable for the whole cycle mem_rd_en=1, and the
// memory must present mem_rdata exactly one cycle after the strobe.
interface mem_view_scanner_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_rd_en, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd_en, output mem_rdata);
endinterface

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern lookup.
module hex_to_seg7
  import mem_view_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup; the caller registers the result
  always_comb begin
    seg = HEX7[nibble];
  end

endmodule

// File: rtl/mem_view_scanner.sv
// Steps an address through memory, fetches the word there and scans it out
// as 8 hex digits on a multiplexed 7-segment display.
module mem_view_scanner
  import mem_view_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int STEP_BIT = 26,
  parameter int SCAN_BIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cntr,
  input  logic                hold,
  input  logic                mem_sel,
  mem_view_scanner_if.master  bus,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic [7:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output state_t              dbg_state
);

  logic              prev_step;
  logic              prev_scan;
  logic              sel_q;
  logic              pending;
  state_t            state;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rd_en_q;
  logic [DATA_W-1:0] shown;
  logic [2:0]        digit;
  logic [3:0]        nibble;
  logic [6:0]        seg_next;

  // Only two bits of the time base matter here
  logic unused_cntr;
  assign unused_cntr = ^cntr;

  logic step_tick;
  logic scan_tick;
  logic sel_change;
  logic refetch_ev;

  assign step_tick  = cntr[STEP_BIT] & ~prev_step;
  assign scan_tick  = cntr[SCAN_BIT] & ~prev_scan;
  assign sel_change = mem_sel ^ sel_q;
  assign refetch_ev = (step_tick & ~hold) | sel_change;

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd_en = rd_en_q;
  assign dbg_state     = state;

  // Rising-edge detectors on the time base and mem_sel change tracking;
  // sel_q follows mem_sel during reset so reset never looks like a change
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_step <= 1'b0;
      prev_scan <= 1'b0;
      sel_q     <= mem_sel;
    end else begin
      prev_step <= cntr[STEP_BIT];
      prev_scan <= cntr[SCAN_BIT];
      sel_q     <= mem_sel;
    end
  end

  // Address counter; wraps naturally at 2**ADDR_W
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr <= '0;
    end else if (step_tick && !hold) begin
      cur_addr <= cur_addr + 1'b1;
    end
  end

  // Fetch sequencer: any events while busy collapse into a single pending
  // refetch of whatever cur_addr is when the sequencer next returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_en_q    <= 1'b0;
      mem_addr_q <= '0;
      shown      <= '0;
      pending    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            state      <= FETCH;
            rd_en_q    <= 1'b1;
            mem_addr_q <= cur_addr;
            pending    <= 1'b0;
          end
        end
        FETCH: begin
          rd_en_q <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          shown <= bus.mem_rdata;
          state <= IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
      // A new event wins over the clear issued on the IDLE->FETCH edge
      if (refetch_ev) begin
        pending <= 1'b1;
      end
    end
  end

  // Nibble of the shown word for the current digit
  always_comb begin
    nibble = shown[{digit, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_next)
  );

  // Digit scan and registered display drive
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
      an    <= 8'hFE;
      seg   <= 7'b1000000;
      dp    <= 1'b1;
    end else begin
      if (scan_tick) begin
        digit <= digit + 1'b1;
      end
      an  <= ~(8'd1 << digit);
      seg <= seg_next;
      dp  <= ~((digit == 3'd7) && mem_sel);
    end
  end

endmodule

// File: tb/tb_mem_view_scanner.sv
// Bench for mem_view_scanner with a fast time base (STEP_BIT=6, SCAN_BIT=2).
module tb_mem_view_scanner;
  import mem_view_pkg::*;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [31:0]   cntr;
  logic          hold;
  logic          mem_sel;
  logic [AW-1:0] cur_addr;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          dp;
  state_t        dbg_state;

  mem_view_scanner_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_view_scanner #(
    .ADDR_W(AW), .DATA_W(DW), .STEP_BIT(6), .SCAN_BIT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cntr      (cntr),
    .hold      (hold),
    .mem_sel   (mem_sel),
    .bus       (bus.master),
    .cur_addr  (cur_addr),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .dbg_state (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference display table and memory contents
  logic [6:0]    hex7_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [DW-1:0] imem [8];
  logic [DW-1:0] dmem [8];
  int            model_addr;

  // Scoreboard of read addresses
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] rd_q  [$];

  // Clock / reset / time base
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cntr <= 32'd0;
    else       cntr <= cntr + 32'd1;
  end

  // Synchronous memory: data one cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_rd_en)
      bus.mem_rdata <= mem_sel ? dmem[bus.mem_addr] : imem[bus.mem_addr];
  end

  // Read monitor
  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
  end

  function automatic logic [DW-1:0] cur_word(int a);
    return mem_sel ? dmem[a % 8] : imem[a % 8];
  endfunction

  // Wait for the next rising edge of cntr[6]; advance the model unless held
  task automatic wait_step();
    logic p;
    bit   ok;
    ok = 0;
    p  = cntr[6];
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cntr[6] && !p) begin ok = 1; break; end
      p = cntr[6];
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL step_wait: no cntr[6] edge within 300 cycles");
    end
    if (!hold) model_addr = (model_addr + 1) % 8;
  endtask

  // Wait for a read strobe, check its address and width, let the word settle
  task automatic wait_fetch(input int exp_addr, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_rd_timeout: no mem_rd_en within 300 cycles", name);
    end else begin
      tests_run++;
      if (bus.mem_addr !== exp_addr[AW-1:0]) begin
        tests_failed++;
        $display("FAIL %s_mem_addr: got %0d expected %0d", name, bus.mem_addr, exp_addr);
      end
      @(negedge clk);
      tests_run++;
      if (bus.mem_rd_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_rd_width: mem_rd_en still %b after one cycle", name, bus.mem_rd_en);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Compare observed read addresses against the expected queue
  task automatic check_fetches(input string name);
    logic [AW-1:0] e, g;
    tests_run++;
    if (rd_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_rd_count: got %0d reads expected %0d", name, rd_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rd_q.size() > 0) begin
      e = exp_q.pop_front();
      g = rd_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL %s_rd_addr: got %0d expected %0d", name, g, e);
      end
    end
    exp_q.delete();
    rd_q.delete();
  endtask

  // Observe n digit changes, checking anode shape, segments and dp
  task automatic check_display(input logic [DW-1:0] word, input int n, input string name);
    logic [7:0] prev;
    int         idx;
    bit         ok;
    for (int k = 0; k < n; k++) begin
      prev = an;
      ok = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (an !== prev) begin ok = 1; break; end
      end
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL %s_scan_timeout: an stuck at %h", name, an);
        return;
      end
      idx = -1;
      for (int i = 0; i < 8; i++) if (an === ~(8'd1 << i)) idx = i;
      tests_run++;
      if (idx < 0) begin
        tests_failed++;
        $display("FAIL %s_an_onecold: got %h", name, an);
      end else begin
        tests_run++;
        if (seg !== hex7_ref[(word >> (4 * idx)) & 32'hF]) begin
          tests_failed++;
          $display("FAIL %s_seg: digit %0d got %h expected %h", name, idx, seg,
                   hex7_ref[(word >> (4 * idx)) & 32'hF]);
        end
        tests_run++;
        if (dp !== ((idx == 7 && mem_sel) ? 1'b0 : 1'b1)) begin
          tests_failed++;
          $display("FAIL %s_dp: digit %0d sel %b got %b", name, idx, mem_sel, dp);
        end
      end
    end
  endtask

  // Count cycles from reset release to the first strobe (expected: 2nd cycle)
  task automatic check_auto_fetch(input string name);
    int  n;
    bit  ok;
    ok = 0;
    n  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n++;
      if (bus.mem_rd_en) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok || n != 1) begin
      tests_failed++;
      $display("FAIL %s_auto_latency: rd_en seen=%0d after %0d edges expected after 1", name, ok, n);
    end
    tests_run++;
    if (bus.mem_addr !== '0) begin
      tests_failed++;
      $display("FAIL %s_auto_addr: got %0d expected 0", name, bus.mem_addr);
    end
    exp_q.push_back('0);
    model_addr = 0;
    repeat (6) @(negedge clk);
    check_fetches(name);
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (bus.mem_rd_en !== 1'b0) begin tests_failed++; $display("FAIL %s_rd_en: got %b expected 0", name, bus.mem_rd_en); end
    tests_run++;
    if (cur_addr !== '0) begin tests_failed++; $display("FAIL %s_cur_addr: got %0d expected 0", name, cur_addr); end
    tests_run++;
    if (an !== 8'hFE) begin tests_failed++; $display("FAIL %s_an: got %h expected fe", name, an); end
    tests_run++;
    if (seg !== 7'h40) begin tests_failed++; $display("FAIL %s_seg: got %h expected 40", name, seg); end
    tests_run++;
    if (dp !== 1'b1) begin tests_failed++; $display("FAIL %s_dp: got %b expected 1", name, dp); end
    tests_run++;
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL %s_state: got %0d expected IDLE", name, dbg_state); end
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b1; mem_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    tests_run++;
    if (bus.mem_addr !== '0) begin tests_failed++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    reset = 1'b0;
    rd_q.delete();
    check_auto_fetch("reset");
    check_display(imem[0], 8, "reset_disp");
    hold = 1'b0;
  endtask

  task automatic test_step();
    for (int i = 0; i < 8; i++) begin
      wait_step();
      exp_q.push_back(model_addr[AW-1:0]);
      wait_fetch(model_addr, "step");
      tests_run++;
      if (cur_addr !== model_addr[AW-1:0]) begin
        tests_failed++;
        $display("FAIL step_cur_addr: got %0d expected %0d", cur_addr, model_addr);
      end
      check_fetches("step");
      check_display(cur_word(model_addr), 8, "step_disp");
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    repeat (3) wait_step();
    repeat (5) @(negedge clk);
    tests_run++;
    if (cur_addr !== model_addr[AW-1:0]) begin
      tests_failed++;
      $display("FAIL hold_cur_addr: got %0d expected %0d", cur_addr, model_addr);
    end
    check_fetches("hold");
    hold = 1'b0;
    wait_step();
    exp_q.push_back(model_addr[AW-1:0]);
    wait_fetch(model_addr, "unhold");
    check_fetches("unhold");
  endtask

  task automatic test_sel_toggle();
    bit ok;
    wait_step();
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL sel_first_rd: no strobe within 20 cycles"); end
    mem_sel = 1'b1;
    exp_q.push_back(model_addr[AW-1:0]);
    exp_q.push_back(model_addr[AW-1:0]);
    repeat (25) @(negedge clk);
    check_fetches("sel_toggle");
    check_display(cur_word(model_addr), 8, "sel_disp");
  endtask

  task automatic test_scan();
    bit ok;
    logic [DW-1:0] w;
    int idx;
    hold = 1'b1;
    w = cur_word(model_addr);
    ok = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (an === 8'h7F) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL scan_sync: an never 7f, got %h", an); end
    for (int k = 0; k < 16; k++) begin
      check_display(w, 1, "scan");
      idx = k % 8;
      tests_run++;
      if (an !== ~(8'd1 << idx)) begin
        tests_failed++;
        $display("FAIL scan_order: step %0d got %h expected %h", k, an, ~(8'd1 << idx));
      end
    end
    check_fetches("scan_quiet");
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_step();
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rmid_first_rd: no strobe within 20 cycles"); end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rmid");
    @(negedge clk);
    reset = 1'b0;
    hold = 1'b1;
    rd_q.delete();
    exp_q.delete();
    check_auto_fetch("rmid");
    check_display(cur_word(0), 8, "rmid_disp");
    hold = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b1; mem_sel = 1'b0;
    model_addr = 0;
    for (int i = 0; i < 8; i++) begin
      imem[i] = $urandom;
      dmem[i] = $urandom;
    end
    imem[0] = 32'h1234ABCD;
    test_reset();
    test_step();
    test_hold();
    test_sel_toggle();
    test_scan();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
